mbist_march_ctrl: RTL and testbench



---
 rtl/mbist_march_ctrl_pkg.sv | 47 ++++
 rtl/mbist_march_ctrl_if.sv | 29 ++
 rtl/mbist_march_ctrl_cmp.sv | 71 +++++++
 rtl/mbist_march_ctrl.sv | 143 ++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbist_march_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mbist_march_ctrl_pkg
// Shared types and constants for the March C- MBIST sequencer:
//   - state_t    : sequencer FSM states
//   - elem_t     : one March element (direction, op count, op0/op1 type+data)
//   - elem_info(): element table lookup for e0..e5
// -----------------------------------------------------------------------------
package mbist_march_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_ELEM = 6;
    localparam int ELEM_W   = 3;
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

    // opN_wr: 1 = write, 0 = read; opN_one: data polarity (all-1 vs all-0 word)
    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_wr;
        logic op0_one;
        logic op1_wr;
        logic op1_one;
    } elem_t;

    // March C-: {up w0} {up r0,w1} {up r1,w0} {dn r0,w1} {dn r1,w0} {dn r0}
    function automatic elem_t elem_info(input logic [ELEM_W-1:0] idx);
        elem_t e;
        e = '0;
        case (idx)
            3'd0: e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_one: 1'b0, op1_wr: 1'b0, op1_one: 1'b0};
            3'd1: e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b1, op1_one: 1'b1};
            3'd2: e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b1, op1_wr: 1'b1, op1_one: 1'b0};
            3'd3: e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b1, op1_one: 1'b1};
            3'd4: e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b1, op1_wr: 1'b1, op1_one: 1'b0};
            3'd5: e = '{down: 1'b1, two_ops: 1'b0, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b0, op1_one: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// -----------------------------------------------------------------------------
// mbist_march_ctrl_if
// SRAM test port between the March sequencer and the memory under test.
//   mem_en    : access strobe            (master -> slave)
//   mem_we    : 1 = write, 0 = read      (master -> slave)
//   mem_addr  : access address           (master -> slave)
//   mem_wdata : write data               (master -> slave)
//   mem_rdata : read data, 1 cycle after a read strobe (slave -> master)
// -----------------------------------------------------------------------------
interface mbist_march_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mbist_march_ctrl_cmp.sv
// -----------------------------------------------------------------------------
// mbist_cmp
// One-stage read-compare pipeline plus fail reporting.
//   clear     : start accepted, wipe fail status
//   flush     : abort, drop the pending compare
//   rd_valid  : a read is issued this cycle; rd_exp/rd_addr describe it
//   mem_rdata : SRAM read data, valid the cycle after rd_valid
//   fail      : sticky mismatch flag
//   fail_addr : address of the first mismatch since clear
//   fail_count: saturating number of mismatching reads
// -----------------------------------------------------------------------------
module mbist_cmp #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              flush,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              vld_reg;
    logic [DATA_W-1:0] exp_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              fail_reg;
    logic [ADDR_W-1:0] fail_addr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mismatch;

    assign mismatch = vld_reg && !flush && (mem_rdata != exp_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg       <= 1'b0;
            exp_reg       <= '0;
            addr_reg      <= '0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            vld_reg  <= rd_valid && !flush;
            exp_reg  <= rd_exp;
            addr_reg <= rd_addr;
            if (clear) begin
                fail_reg      <= 1'b0;
                fail_addr_reg <= '0;
                cnt_reg       <= '0;
            end else if (mismatch) begin
                fail_reg <= 1'b1;
                // keep the first failing address for the repair logic
                if (!fail_reg)
                    fail_addr_reg <= addr_reg;
                if (cnt_reg != CNT_MAX)
                    cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign fail       = fail_reg;
    assign fail_addr  = fail_addr_reg;
    assign fail_count = cnt_reg;
endmodule

// File: rtl/mbist_march_ctrl.sv
// -----------------------------------------------------------------------------
// mbist_march_ctrl
// March C- sequencer for the SRAM under test.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : level, sampled in IDLE/DONE only
//   abort      : returns to IDLE from RUN/DRAIN
//   mem        : SRAM test port (master side)
//   busy       : RUN or DRAIN
//   done       : DONE
//   fail, fail_addr, fail_count : result for the repair logic
// One memory op per RUN cycle; element e ends on a terminal-count address
// compare, then the next element starts at its own start address.
// -----------------------------------------------------------------------------
module mbist_march_ctrl
    import mbist_march_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    mbist_march_ctrl_if.master  mem,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [CNT_W-1:0]    fail_count
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state_reg, state_next;
    logic [ELEM_W-1:0] elem_reg, elem_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              op_reg, op_next;

    elem_t             cur;
    logic              cur_wr;
    logic              cur_one;
    logic [ADDR_W-1:0] last_addr;
    logic              run;
    logic              launch;
    logic              flush;

    assign cur       = elem_info(elem_reg);
    assign cur_wr    = op_reg ? cur.op1_wr  : cur.op0_wr;
    assign cur_one   = op_reg ? cur.op1_one : cur.op0_one;
    assign last_addr = cur.down ? '0 : ADDR_MAX;
    assign run       = (state_reg == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            elem_reg  <= '0;
            addr_reg  <= '0;
            op_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            elem_reg  <= elem_next;
            addr_reg  <= addr_next;
            op_reg    <= op_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        elem_next  = elem_reg;
        addr_next  = addr_reg;
        op_next    = op_reg;
        launch     = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            // abort has priority over a simultaneous start
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_next = RUN;
                    elem_next  = '0;
                    addr_next  = '0;
                    op_next    = 1'b0;
                    launch     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else if (cur.two_ops && !op_reg) begin
                    op_next = 1'b1;
                end else begin
                    op_next = 1'b0;
                    if (addr_reg == last_addr) begin
                        if (elem_reg == LAST_ELEM) begin
                            state_next = DRAIN;
                        end else begin
                            elem_next = elem_reg + 1'b1;
                            addr_next = elem_info(elem_reg + 1'b1).down ? ADDR_MAX : '0;
                        end
                    end else begin
                        addr_next = cur.down ? addr_reg - 1'b1 : addr_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // last compare happens here; no memory access
                if (abort) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem.mem_en    = run;
    assign mem.mem_we    = run && cur_wr;
    assign mem.mem_addr  = run ? addr_reg : '0;
    assign mem.mem_wdata = (run && cur_wr) ? {DATA_W{cur_one}} : '0;

    assign busy = (state_reg == RUN) || (state_reg == DRAIN);
    assign done = (state_reg == DONE);

    mbist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (launch),
        .flush      (flush),
        .rd_valid   (run && !cur_wr && !abort),
        .rd_exp     ({DATA_W{cur_one}}),
        .rd_addr    (addr_reg),
        .mem_rdata  (mem.mem_rdata),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_count (fail_count)
    );
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mbist_march_ctrl
// Table of fault scenarios run through a 16x8 SRAM model with injectable
// stuck-at bits and an intra-word coupling (bit1 reads as ~bit0 for
// addresses >= cpl_lo), followed by hand-written abort, start-held,
// restart-from-DONE and asynchronous reset sequences.
// -----------------------------------------------------------------------------
module tb_mbist_march_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int N      = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [CNT_W-1:0]  fail_count;

    mbist_march_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    mbist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mem        (mif),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM model with faults ----------------
    logic [DATA_W-1:0] mem_arr [N];
    logic [DATA_W-1:0] sa1 [N];
    logic [DATA_W-1:0] sa0 [N];
    int                cpl_lo = N;

    function automatic logic [DATA_W-1:0] read_word(input int a);
        logic [DATA_W-1:0] v;
        v = (mem_arr[a] | sa1[a]) & ~sa0[a];
        if (a >= cpl_lo) v[1] = ~v[0];
        return v;
    endfunction

    initial mif.mem_rdata = '0;
    always @(posedge clk) begin
        if (mif.mem_en) begin
            if (mif.mem_we) mem_arr[mif.mem_addr] <= mif.mem_wdata;
            else            mif.mem_rdata <= read_word(int'(mif.mem_addr));
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
            mem_arr[i] = '0;
        end
        cpl_lo = N;
    endtask

    // address/data must be 0 whenever the strobe is low
    int idle_err = 0;
    always @(negedge clk) begin
        if (!mif.mem_en && (mif.mem_we || mif.mem_addr != '0 || mif.mem_wdata != '0))
            idle_err++;
    end

    // ---------------- checking ----------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            passed++;
    endtask

    // expected March C- op stream, written out from the element list
    bit                exp_we [$];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_wd [$];

    task automatic build_ops();
        int nops [6] = '{1, 2, 2, 2, 2, 1};
        bit dn   [6] = '{0, 0, 0, 1, 1, 1};
        bit w0   [6] = '{1, 0, 0, 0, 0, 0};
        bit d0   [6] = '{0, 0, 1, 0, 1, 0};
        bit d1   [6] = '{0, 1, 0, 1, 0, 0};
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                a = dn[e] ? (N - 1 - k) : k;
                exp_we.push_back(w0[e]);
                exp_addr.push_back(ADDR_W'(a));
                exp_wd.push_back(d0[e] ? 8'hFF : 8'h00);
                if (nops[e] == 2) begin
                    exp_we.push_back(1'b1);
                    exp_addr.push_back(ADDR_W'(a));
                    exp_wd.push_back(d1[e] ? 8'hFF : 8'h00);
                end
            end
        end
    endtask

    // Pulses start, then follows the run until done (bounded). Counts busy
    // and strobe cycles, checks each op against the expected stream and
    // samples fail_addr at RUN cycle 60.
    task automatic do_run(output int busy_cyc, output int en_cyc, output int op_err,
                          output int mid_addr, output bit timed_out);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cyc = 0; en_cyc = 0; op_err = 0; mid_addr = -1; timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy_cyc == 60) mid_addr = int'(fail_addr);
            if (busy) busy_cyc++;
            if (mif.mem_en) begin
                if (en_cyc >= exp_we.size()) op_err++;
                else if (mif.mem_we !== exp_we[en_cyc] || mif.mem_addr !== exp_addr[en_cyc] ||
                         (exp_we[en_cyc] && mif.mem_wdata !== exp_wd[en_cyc]))
                    op_err++;
                en_cyc++;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int           sa1_addr;
        logic [7:0]   sa1_mask;
        int           sa0_addr;
        logic [7:0]   sa0_mask;
        int           cpl_lo;
        logic         exp_fail;
        int           exp_addr;
        int           exp_cnt;
        int           exp_mid;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int bc, ec, oe, ma, cyc;
        bit to;

        build_ops();
        clear_faults();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_mem_en", mif.mem_en, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //          sa1@  mask   sa0@  mask   cpl  fail addr cnt mid
        vecs[0] = '{-1,   8'h00, -1,   8'h00, 16,  1'b0, 0,  0,  0};
        vecs[1] = '{5,    8'h01, -1,   8'h00, 16,  1'b1, 5,  3,  5};
        vecs[2] = '{3,    8'h01, 10,   8'h80, 16,  1'b1, 3,  5,  3};
        vecs[3] = '{-1,   8'h00, 2,    8'h80, 8,   1'b1, 8,  15, 8};

        for (int v = 0; v < 4; v++) begin
            clear_faults();
            if (vecs[v].sa1_addr >= 0) sa1[vecs[v].sa1_addr] = vecs[v].sa1_mask;
            if (vecs[v].sa0_addr >= 0) sa0[vecs[v].sa0_addr] = vecs[v].sa0_mask;
            cpl_lo = vecs[v].cpl_lo;
            do_run(bc, ec, oe, ma, to);
            check($sformatf("v%0d_timeout", v), 32'(to), 0);
            check($sformatf("v%0d_busy_cycles", v), bc, 161);
            check($sformatf("v%0d_mem_en_cycles", v), ec, 160);
            check($sformatf("v%0d_op_seq_errors", v), oe, 0);
            check($sformatf("v%0d_done", v), done, 1);
            check($sformatf("v%0d_fail", v), fail, 32'(vecs[v].exp_fail));
            check($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].exp_addr);
            check($sformatf("v%0d_fail_count", v), fail_count, vecs[v].exp_cnt);
            check($sformatf("v%0d_mid_fail_addr", v), ma, vecs[v].exp_mid);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_hold", v), done, 1);
        end

        // abort at RUN cycle 50: fail status held, state back to IDLE
        clear_faults();
        sa1[5] = 8'h01;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_mem_en", mif.mem_en, 0);
        check("abort_done", done, 0);
        check("abort_fail_held", fail, 1);
        check("abort_fail_addr_held", fail_addr, 5);
        check("abort_fail_count_held", fail_count, 1);

        // start and abort together in IDLE: stays IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);

        // full run after abort: counters restart from zero
        do_run(bc, ec, oe, ma, to);
        check("rerun_timeout", 32'(to), 0);
        check("rerun_busy_cycles", bc, 161);
        check("rerun_fail_count", fail_count, 3);
        check("rerun_fail_addr", fail_addr, 5);

        // start held high from DONE through RUN: clears status, no restart
        clear_faults();
        start = 1'b1;
        @(posedge clk); #1;
        check("held_clear_fail", fail, 0);
        check("held_clear_count", fail_count, 0);
        check("held_clear_done", done, 0);
        cyc = 0;
        while (!done && cyc < 400) begin
            if (cyc == 150) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("held_done_cycle", cyc, 161);
        check("held_fail", fail, 0);

        // re-pulse start in DONE: new run begins next cycle
        sa1[5] = 8'h01;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("repulse_done", done, 0);
        check("repulse_busy", busy, 1);

        // asynchronous reset mid-run
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("pre_rst_fail", fail, 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mem_en", mif.mem_en, 0);
        check("arst_fail", fail, 0);
        check("arst_fail_count", fail_count, 0);
        check("arst_mem_addr", mif.mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("idle_bus_zero_errors", idle_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
